// File: rtl/reg_pc_unit.sv
// 6502 program counter: byte-wise loads, increment, relative branch with an
// optional page-cross fix-up cycle, and hold-when-idle registered bus outputs.
module reg_pc_unit #(
  parameter int                  DW           = 8,
  parameter logic [2*DW-1:0]     RESET_PC     = 16'hFFFC,
  parameter bit                  BRANCH_FIXUP = 1'b1
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            PCL_LOAD_ADL,
  input  logic            PCH_LOAD_ADH,
  input  logic            INC,
  input  logic            BRANCH,
  input  logic [DW-1:0]   OFFSET,
  input  logic [DW-1:0]   ADL_DATA,
  input  logic [DW-1:0]   ADH_DATA,
  input  logic            DB_L_BUS_ENABLE,
  input  logic            DB_H_BUS_ENABLE,
  input  logic            ADL_BUS_ENABLE,
  input  logic            ADH_BUS_ENABLE,
  output logic [DW-1:0]   DB_BUS,
  output logic [DW-1:0]   ADL_BUS,
  output logic [DW-1:0]   ADH_BUS,
  output logic [2*DW-1:0] PC,
  output logic            BUSY,
  output logic            PAGE_CROSS
);

  // state  | meaning
  // IDLE   | accept loads / branch / increment
  // FIXUP  | apply the deferred PCH +/-1 after a page-crossing branch
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FIXUP = 1'b1;

  localparam logic [DW-1:0]   BYTE_ONE = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [2*DW-1:0] PC_ONE   = {{(2*DW-1){1'b0}}, 1'b1};

  logic [0:0]      state;
  logic [DW-1:0]   pcl;
  logic [DW-1:0]   pch;
  logic            fix_fwd;
  logic            page_cross_q;
  logic [DW-1:0]   db_q;
  logic [DW-1:0]   adl_q;
  logic [DW-1:0]   adh_q;

  logic [DW:0]     br_sum;
  logic            br_neg;
  logic            br_cross;
  logic [2*DW-1:0] pc_inc;
  logic            any_load;

  // A negative offset without carry, or a non-negative one with carry, leaves the page
  assign br_sum   = {1'b0, pcl} + {1'b0, OFFSET};
  assign br_neg   = OFFSET[DW-1];
  assign br_cross = br_neg ? ~br_sum[DW] : br_sum[DW];
  assign pc_inc   = {pch, pcl} + PC_ONE;
  assign any_load = PCL_LOAD_ADL | PCH_LOAD_ADH;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state        <= ST_IDLE;
      pcl          <= RESET_PC[DW-1:0];
      pch          <= RESET_PC[2*DW-1:DW];
      fix_fwd      <= 1'b0;
      page_cross_q <= 1'b0;
      db_q         <= '0;
      adl_q        <= '0;
      adh_q        <= '0;
    end else begin
      if (DB_H_BUS_ENABLE) begin
        db_q <= pch;
      end else if (DB_L_BUS_ENABLE) begin
        db_q <= pcl;
      end
      if (ADL_BUS_ENABLE) begin
        adl_q <= pcl;
      end
      if (ADH_BUS_ENABLE) begin
        adh_q <= pch;
      end

      case (state)
        ST_IDLE: begin
          if (any_load) begin
            if (PCL_LOAD_ADL) begin
              pcl <= ADL_DATA;
            end
            if (PCH_LOAD_ADH) begin
              pch <= ADH_DATA;
            end
            page_cross_q <= 1'b0;
          end else if (BRANCH) begin
            pcl          <= br_sum[DW-1:0];
            page_cross_q <= br_cross;
            if (br_cross) begin
              if (BRANCH_FIXUP) begin
                state   <= ST_FIXUP;
                fix_fwd <= ~br_neg;
              end else begin
                pch <= br_neg ? (pch - BYTE_ONE) : (pch + BYTE_ONE);
              end
            end
          end else if (INC) begin
            {pch, pcl} <= pc_inc;
          end
        end
        ST_FIXUP: begin
          pch   <= fix_fwd ? (pch + BYTE_ONE) : (pch - BYTE_ONE);
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign PC         = {pch, pcl};
  assign BUSY       = (state == ST_FIXUP);
  assign PAGE_CROSS = page_cross_q;
  assign DB_BUS     = db_q;
  assign ADL_BUS    = adl_q;
  assign ADH_BUS    = adh_q;

endmodule

// File: tb/tb_reg_pc_unit.sv
// Scoreboard bench for reg_pc_unit: directed stimulus queues expected values,
// a negedge monitor pops and compares them against two instances (fix-up on/off).
module tb_reg_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        ld_l, ld_h, inc, br;
  logic [7:0]  off, adl_d, adh_d;
  logic        db_l_en, db_h_en, adl_en, adh_en;

  logic [7:0]  db0, adl0, adh0, db1, adl1, adh1;
  logic [15:0] pc0, pc1;
  logic        busy0, busy1, pcx0, pcx1;

  reg_pc_unit #(.DW(8), .RESET_PC(16'hFFFC), .BRANCH_FIXUP(1'b1)) u_dut (
    .CLK(clk), .RESET_N(rst_n), .PCL_LOAD_ADL(ld_l), .PCH_LOAD_ADH(ld_h),
    .INC(inc), .BRANCH(br), .OFFSET(off), .ADL_DATA(adl_d), .ADH_DATA(adh_d),
    .DB_L_BUS_ENABLE(db_l_en), .DB_H_BUS_ENABLE(db_h_en),
    .ADL_BUS_ENABLE(adl_en), .ADH_BUS_ENABLE(adh_en),
    .DB_BUS(db0), .ADL_BUS(adl0), .ADH_BUS(adh0), .PC(pc0),
    .BUSY(busy0), .PAGE_CROSS(pcx0)
  );

  reg_pc_unit #(.DW(8), .RESET_PC(16'hFFFC), .BRANCH_FIXUP(1'b0)) u_dut_nf (
    .CLK(clk), .RESET_N(rst_n), .PCL_LOAD_ADL(ld_l), .PCH_LOAD_ADH(ld_h),
    .INC(inc), .BRANCH(br), .OFFSET(off), .ADL_DATA(adl_d), .ADH_DATA(adh_d),
    .DB_L_BUS_ENABLE(db_l_en), .DB_H_BUS_ENABLE(db_h_en),
    .ADL_BUS_ENABLE(adl_en), .ADH_BUS_ENABLE(adh_en),
    .DB_BUS(db1), .ADL_BUS(adl1), .ADH_BUS(adh1), .PC(pc1),
    .BUSY(busy1), .PAGE_CROSS(pcx1)
  );

  // mask bits: 0 pc, 1 busy, 2 page_cross, 3 db, 4 adl, 5 adh
  typedef struct {
    string       name;
    int          dut;
    int          cyc;
    logic [5:0]  m;
    logic [15:0] pc;
    logic        busy;
    logic        pcx;
    logic [7:0]  db;
    logic [7:0]  adl;
    logic [7:0]  adh;
  } exp_t;

  exp_t exp_q[$];
  int   cycle = 0;
  int   total = 0;
  int   bad   = 0;
  bit   done  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic void cmp(string n, string f, logic [15:0] got, logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s.%s: got %h want %h", n, f, got, want);
    end
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cycle) begin
        e = exp_q.pop_front();
        if (e.dut == 0) begin
          if (e.m[0]) cmp(e.name, "pc",   pc0,   e.pc);
          if (e.m[1]) cmp(e.name, "busy", {15'd0, busy0}, {15'd0, e.busy});
          if (e.m[2]) cmp(e.name, "pcx",  {15'd0, pcx0},  {15'd0, e.pcx});
          if (e.m[3]) cmp(e.name, "db",   {8'd0, db0},  {8'd0, e.db});
          if (e.m[4]) cmp(e.name, "adl",  {8'd0, adl0}, {8'd0, e.adl});
          if (e.m[5]) cmp(e.name, "adh",  {8'd0, adh0}, {8'd0, e.adh});
        end else begin
          if (e.m[0]) cmp(e.name, "pc",   pc1,   e.pc);
          if (e.m[1]) cmp(e.name, "busy", {15'd0, busy1}, {15'd0, e.busy});
          if (e.m[2]) cmp(e.name, "pcx",  {15'd0, pcx1},  {15'd0, e.pcx});
          if (e.m[3]) cmp(e.name, "db",   {8'd0, db1},  {8'd0, e.db});
          if (e.m[4]) cmp(e.name, "adl",  {8'd0, adl1}, {8'd0, e.adl});
          if (e.m[5]) cmp(e.name, "adh",  {8'd0, adh1}, {8'd0, e.adh});
        end
      end
    end
  end

  // expectation for the value seen after the next rising edge
  task automatic expect_v(string n, int d, logic [5:0] m, logic [15:0] p,
                          logic b, logic x, logic [7:0] db, logic [7:0] al, logic [7:0] ah);
    exp_t e;
    e.name = n; e.dut = d; e.cyc = cycle + 1; e.m = m; e.pc = p;
    e.busy = b; e.pcx = x; e.db = db; e.adl = al; e.adh = ah;
    exp_q.push_back(e);
  endtask

  task automatic drive(logic l_l, logic l_h, logic i, logic b, logic [7:0] o,
                       logic [7:0] al, logic [7:0] ah);
    ld_l = l_l; ld_h = l_h; inc = i; br = b; off = o; adl_d = al; adh_d = ah;
  endtask

  task automatic buses(logic dl, logic dh, logic ale, logic ahe);
    db_l_en = dl; db_h_en = dh; adl_en = ale; adh_en = ahe;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(string n, logic [15:0] v);
    drive(1, 1, 0, 0, 8'h00, v[7:0], v[15:8]);
    expect_v(n, 0, 6'b000101, v, 0, 0, 0, 0, 0);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
    buses(1, 1, 1, 1);
    @(negedge clk);

    // reset overrides INC and bus enables
    expect_v("rst0", 0, 6'b111111, 16'hFFFC, 0, 0, 8'h00, 8'h00, 8'h00);
    tick();
    expect_v("rst1", 0, 6'b111111, 16'hFFFC, 0, 0, 8'h00, 8'h00, 8'h00);
    expect_v("rst1_nf", 1, 6'b111111, 16'hFFFC, 0, 0, 8'h00, 8'h00, 8'h00);
    tick();

    rst_n = 1'b1;
    buses(0, 0, 0, 0);
    expect_v("inc1", 0, 6'b000001, 16'hFFFD, 0, 0, 0, 0, 0); tick();
    expect_v("inc2", 0, 6'b000001, 16'hFFFE, 0, 0, 0, 0, 0); tick();
    expect_v("inc3", 0, 6'b000001, 16'hFFFF, 0, 0, 0, 0, 0); tick();
    expect_v("inc_wrap", 0, 6'b000111, 16'h0000, 0, 0, 0, 0, 0); tick();

    drive(1, 1, 1, 0, 8'h00, 8'h34, 8'h12);
    expect_v("ld_both", 0, 6'b000111, 16'h1234, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 8'h00, 8'hFF, 8'h77);
    expect_v("ld_pcl", 0, 6'b000001, 16'h12FF, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
    expect_v("inc_carry", 0, 6'b000001, 16'h1300, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 1, 1, 8'h10, 8'h00, 8'h56);
    expect_v("ld_pch", 0, 6'b000001, 16'h5600, 0, 0, 0, 0, 0); tick();

    load("ld_1210", 16'h1210);
    drive(0, 0, 1, 1, 8'h05, 8'h00, 8'h00);
    expect_v("br_fwd", 0, 6'b000111, 16'h1215, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    expect_v("br_fwd_idle", 0, 6'b000011, 16'h1215, 0, 0, 0, 0, 0); tick();
    load("ld_1210b", 16'h1210);
    drive(0, 0, 0, 1, 8'hF0, 8'h00, 8'h00);
    expect_v("br_back", 0, 6'b000111, 16'h1200, 0, 0, 0, 0, 0); tick();

    load("ld_12f0", 16'h12F0);
    drive(0, 0, 0, 1, 8'h20, 8'h00, 8'h00);
    expect_v("xfwd_e1", 0, 6'b000111, 16'h1210, 1, 1, 0, 0, 0); tick();
    drive(1, 1, 1, 1, 8'h20, 8'h99, 8'h99);
    expect_v("xfwd_e2", 0, 6'b000111, 16'h1310, 0, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    expect_v("xfwd_hold", 0, 6'b000111, 16'h1310, 0, 1, 0, 0, 0); tick();

    load("ld_fff0", 16'hFFF0);
    drive(0, 0, 0, 1, 8'h20, 8'h00, 8'h00);
    expect_v("wrap_e1", 0, 6'b000011, 16'hFF10, 1, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    expect_v("wrap_e2", 0, 6'b000011, 16'h0010, 0, 0, 0, 0, 0); tick();

    load("ld_0005", 16'h0005);
    drive(0, 0, 0, 1, 8'hFB, 8'h00, 8'h00);
    expect_v("br_m5", 0, 6'b000111, 16'h0000, 0, 0, 0, 0, 0); tick();

    load("ld_0002", 16'h0002);
    drive(0, 0, 0, 1, 8'hFC, 8'h00, 8'h00);
    expect_v("xback_e1", 0, 6'b000111, 16'h00FE, 1, 1, 0, 0, 0);
    expect_v("xback_nf", 1, 6'b000111, 16'hFFFE, 0, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    expect_v("xback_e2", 0, 6'b000111, 16'hFFFE, 0, 1, 0, 0, 0);
    expect_v("xback_nf2", 1, 6'b000011, 16'hFFFE, 0, 0, 0, 0, 0); tick();

    drive(1, 1, 0, 1, 8'h20, 8'hCD, 8'hAB);
    expect_v("ld_beats_br", 0, 6'b000111, 16'hABCD, 0, 0, 0, 0, 0); tick();

    drive(0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
    buses(1, 1, 1, 0);
    expect_v("bus_cap", 0, 6'b111001, 16'hABCE, 0, 0, 8'hAB, 8'hCD, 8'h00); tick();
    drive(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    buses(0, 0, 0, 0);
    expect_v("bus_hold", 0, 6'b111001, 16'hABCE, 0, 0, 8'hAB, 8'hCD, 8'h00); tick();
    buses(1, 0, 0, 1);
    expect_v("bus_dbl", 0, 6'b111001, 16'hABCE, 0, 0, 8'hCE, 8'hCD, 8'hAB); tick();
    buses(0, 0, 0, 0);

    load("ld_12f0b", 16'h12F0);
    drive(0, 0, 0, 1, 8'h20, 8'h00, 8'h00);
    expect_v("rfix_e1", 0, 6'b000011, 16'h1210, 1, 0, 0, 0, 0); tick();
    rst_n = 1'b0;
    drive(0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
    expect_v("rfix_rst", 0, 6'b111111, 16'hFFFC, 0, 0, 8'h00, 8'h00, 8'h00); tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    expect_v("rfix_after", 0, 6'b000111, 16'hFFFC, 0, 0, 0, 0, 0); tick();

    tick();
    tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_pc_unit.md
# reg_pc_unit

Clocked, parametrised program counter unit for the 6502 datapath, replacing the separate PCL/PCLS/PCH latch registers with a single synchronous block. It holds the program counter as a low byte and a high byte and supports byte-wise loads from ADL/ADH, full-width increment, and signed relative branches. For branches it has an optional page-cross fix-up cycle that mirrors the original 6502 timing. Registered bus outputs keep their last driven value when not enabled, as the existing bus registers do.

## Interface
- DW, 8: byte width; PC is 2*DW bits
- RESET_PC, 16'hFFFC: PC value after reset (2*DW bits)
- BRANCH_FIXUP, 1: 1 = a page-crossing branch corrects PCH in an extra cycle; 0 = a branch updates the full PC in one cycle

- CLK  input  1  clock; all state changes on the rising edge
- RESET_N  input  1  reset, synchronous, active-low
- PCL_LOAD_ADL  input  1  load PCL from ADL_DATA
- PCH_LOAD_ADH  input  1  load PCH from ADH_DATA
- INC  input  1  increment the PC by 1
- BRANCH  input  1  add sign-extended OFFSET to the PC
- OFFSET  input  DW  two's-complement branch offset
- ADL_DATA  input  DW  ADL bus input
- ADH_DATA  input  DW  ADH bus input
- DB_L_BUS_ENABLE  input  1  drive PCL onto DB_BUS
- DB_H_BUS_ENABLE  input  1  drive PCH onto DB_BUS (wins over DB_L)
- ADL_BUS_ENABLE  input  1  drive PCL onto ADL_BUS
- ADH_BUS_ENABLE  input  1  drive PCH onto ADH_BUS
- DB_BUS  output  DW  registered data bus output
- ADL_BUS  output  DW  registered ADL output
- ADH_BUS  output  DW  registered ADH output
- PC  output  2*DW  current {PCH, PCL}
- BUSY  output  1  high during the FIXUP cycle
- PAGE_CROSS  output  1  sticky flag: the last branch crossed a page

## Operation
- States: IDLE and FIXUP. FIXUP is reachable only when BRANCH_FIXUP=1.
- IDLE command priority, per cycle:
  - Any load (PCL_LOAD_ADL or PCH_LOAD_ADH) beats BRANCH, which beats INC.
  - The two loads are independent. If only one is asserted, the other byte is unchanged.
  - If either load is asserted, INC and BRANCH are ignored.
  - Any load clears PAGE_CROSS.
- INC: PC <= PC+1 modulo 2^(2*DW). The carry propagates from PCL into PCH in the same cycle, so FFFF becomes 0000.
- BRANCH:
  - New PCL = (PCL + OFFSET) mod 2^DW.
  - A page cross occurs when OFFSET is non-negative and the unsigned add carries, or when OFFSET is negative and the add does not carry.
  - PAGE_CROSS <= page cross.
  - BRANCH_FIXUP=0: PCH <= PCH + 1 (forward cross), PCH - 1 (backward cross), or unchanged, all in the same cycle.
  - BRANCH_FIXUP=1 with a page cross: PCH is held and the state moves to FIXUP. The next cycle applies PCH ±1 (mod 2^DW) and returns to IDLE.
  - BRANCH_FIXUP=1 without a page cross: stay in IDLE.
- FIXUP lasts exactly one cycle. During it, all loads, INC and BRANCH are ignored and not queued. BUSY=1 in FIXUP only.
- Bus outputs:
  - On each edge where an enable is high, the corresponding output register captures the pre-update byte.
  - DB_BUS takes PCH if DB_H_BUS_ENABLE is high, else PCL if DB_L_BUS_ENABLE is high.
  - An output holds its value while its enable is low.
  - Enables are honoured in both states.
- PC is combinational from the state registers.

## Timing
- Reset (RESET_N low at an edge):
  - PC = RESET_PC, state = IDLE, BUSY = 0, PAGE_CROSS = 0.
  - DB_BUS, ADL_BUS and ADH_BUS = 0.
  - Reset overrides every command.
  - Reset during FIXUP abandons the fix-up; PCH = RESET_PC high byte.
- Latency:
  - Command to PC: 1 edge.
  - Page-crossing branch with BRANCH_FIXUP=1: 2 edges until PC is final.
  - Bus enable to bus output: 1 edge. The output shows the PC value from before that edge.
- Simultaneous events:
  - Load and BRANCH: load wins and PAGE_CROSS clears.
  - BRANCH and INC: branch only.
  - Commands asserted together with the branch that enters FIXUP are resolved in IDLE by the priority rules; commands in the FIXUP cycle are ignored.
- Wrap-around:
  - PCL add is mod 2^DW.
  - PCH fix-up wraps: FF+1 = 00 and 00-1 = FF.

## Test plan
- Reset: hold RESET_N low 2 cycles with INC=1 -> PC=FFFC, all buses 00, BUSY=0, PAGE_CROSS=0. Release, INC 4 cycles -> PC=0000.
- Loads: ADL_DATA=34, ADH_DATA=12, both loads plus INC=1 -> PC=1234. Next cycle PCL_LOAD_ADL only with ADL_DATA=FF -> PC=12FF. INC -> PC=1300.
- Branch, no cross: PC=1210, OFFSET=05 -> PC=1215, PAGE_CROSS=0, BUSY never high. PC=1210, OFFSET=F0 (-16) -> PC=1200.
- Forward cross, BRANCH_FIXUP=1: PC=12F0, OFFSET=20:
  - Edge 1 -> PC=1210, BUSY=1, PAGE_CROSS=1.
  - Edge 2 -> PC=1310, BUSY=0.
  - Pulse INC during FIXUP -> ignored, PC stays 1310.
- Backward cross and wrap: PC=0005, OFFSET=FB (-5) -> PC=0000 with no cross. PC=0002, OFFSET=FC (-4) -> PC=00FE, then FFFE after fix-up. Repeat with BRANCH_FIXUP=0 -> FFFE after one edge, BUSY=0.
- Bus outputs:
  - PC=ABCD, ADL_BUS_ENABLE and DB_H_BUS_ENABLE high for one cycle with INC -> ADL_BUS=CD, DB_BUS=AB, PC=ABCE. Enables then low -> outputs hold CD/AB.
  - Assert RESET_N low mid-FIXUP -> PC=FFFC, outputs 00.
